// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder slice: FSM encoding and default width.
package add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : add_pkg

// File: rtl/half_adder_cell.sv
// Single half-adder cell; the same cell used by the combinational slice upstream.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder_cell

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one operand bit pair per valid beat, WIDTH-bit sum
// assembled in a shift register and published together with the final carry.
module bit_serial_adder
    import add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [CW-1:0]     count_r;
    logic              carry_r;
    logic [WIDTH-1:0]  shreg_r;
    logic [WIDTH-1:0]  sum_out_r;
    logic              carry_out_r;
    logic              busy_r;
    logic              done_r;
    logic              busy_next_s;
    logic              done_next_s;

    logic              ha0_s;
    logic              ha0_c_s;
    logic              fa_sum_s;
    logic              ha1_c_s;
    logic              fa_carry_s;
    logic              beat_s;
    logic              last_beat_s;

    // Full adder from two half-adder cells; the second cell folds in the stored carry.
    half_adder_cell u_ha0 (
        .a (in_a),
        .b (in_b),
        .s (ha0_s),
        .c (ha0_c_s)
    );

    half_adder_cell u_ha1 (
        .a (ha0_s),
        .b (carry_r),
        .s (fa_sum_s),
        .c (ha1_c_s)
    );

    assign fa_carry_s  = ha0_c_s | ha1_c_s;
    // start wins over in_valid, so an aborting cycle never consumes a beat.
    assign beat_s      = (state_r == SHIFT) && in_valid && !start;
    assign last_beat_s = (count_r == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (ena) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else if (beat_s && last_beat_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode; busy and done are registered from these.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_r)
            DONE: begin
                done_next_s = 1'b1;
            end
            default: begin
                done_next_s = 1'b0;
            end
        endcase
        if (state_next_s == SHIFT) begin
            busy_next_s = 1'b1;
        end else begin
            busy_next_s = 1'b0;
        end
    end

    // Status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (ena) begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end else begin
            busy_r <= busy_r;
            done_r <= done_r;
        end
    end

    // Beat counter, carry, shift register and the published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= '0;
            carry_r     <= 1'b0;
            shreg_r     <= '0;
            sum_out_r   <= '0;
            carry_out_r <= 1'b0;
        end else if (ena) begin
            if (start) begin
                count_r <= '0;
                carry_r <= 1'b0;
                shreg_r <= '0;
            end else if (beat_s) begin
                count_r <= count_r + CW'(1);
                carry_r <= fa_carry_s;
                shreg_r <= {fa_sum_s, shreg_r[WIDTH-1:1]};
                if (last_beat_s) begin
                    sum_out_r   <= {fa_sum_s, shreg_r[WIDTH-1:1]};
                    carry_out_r <= fa_carry_s;
                end else begin
                    sum_out_r   <= sum_out_r;
                    carry_out_r <= carry_out_r;
                end
            end else begin
                count_r <= count_r;
                carry_r <= carry_r;
                shreg_r <= shreg_r;
            end
        end else begin
            count_r     <= count_r;
            carry_r     <= carry_r;
            shreg_r     <= shreg_r;
            sum_out_r   <= sum_out_r;
            carry_out_r <= carry_out_r;
        end
    end

    assign sum_out   = sum_out_r;
    assign carry_out = carry_out_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed scenarios plus randomized
// operands/stalls, checked against plain A+B arithmetic.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic         in_valid;
    logic         in_a;
    logic         in_b;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Runs one addition; stall[k] set means slot k carries no valid beat.
    // Edge numbering: the start edge is edge 0.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] stall,
                          output logic [W-1:0] s, output logic c, output int total, output int lat,
                          output int busy_cnt, output int done_cnt, output bit early, output bit timeout);
        int e, beats, slot, last_e, done_e;
        bit stalled;
        logic [W-1:0] prev;
        prev = sum_out; busy_cnt = 0; done_cnt = 0; early = 1'b0; timeout = 1'b0;
        e = 0; beats = 0; slot = 0; last_e = 0; done_e = -1;
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        if (busy) busy_cnt++;
        while (beats < W && slot < 64) begin
            stalled = (slot < 32) ? stall[slot] : 1'b0;
            if (stalled) begin
                in_valid = 1'b0; in_a = 1'($urandom); in_b = 1'($urandom);
            end else begin
                in_valid = 1'b1; in_a = a[beats]; in_b = b[beats];
            end
            tick(); e++; slot++;
            if (!stalled) begin
                beats++;
                if (beats == W) last_e = e;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (beats < W && sum_out !== prev) early = 1'b1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(); e++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_e < 0) done_e = e;
            end
        end
        if (done_e < 0) timeout = 1'b1;
        s = sum_out; c = carry_out; total = done_e; lat = done_e - last_e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
        #3;
        checks++;
        if (sum_out !== 8'h00 || carry_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_outputs got sum=%0h c=%0b busy=%0b done=%0b exp all zero", sum_out, carry_out, busy, done);
            failures++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_idle got busy=%0b done=%0b exp 0 0", busy, done);
            failures++;
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic c; int total, lat, bc, dc; bit early, to;
        logic [W:0] exp;
        exp = model_add(8'h35, 8'h4A);
        run_op(8'h35, 8'h4A, 32'h0, s, c, total, lat, bc, dc, early, to);
        checks++;
        if (s !== exp[W-1:0] || c !== exp[W]) begin
            $display("FAIL basic_sum got=%0b_%0h exp=%0b_%0h", c, s, exp[W], exp[W-1:0]); failures++;
        end
        checks++;
        if (to || lat !== 1 || total !== W + 1) begin
            $display("FAIL basic_latency got lat=%0d total=%0d timeout=%0b exp lat=1 total=%0d", lat, total, to, W + 1); failures++;
        end
        checks++;
        if (bc !== W || dc !== 1) begin
            $display("FAIL basic_busy_done got busy=%0d done=%0d exp busy=%0d done=1", bc, dc, W); failures++;
        end
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] s; logic c; int total, lat, bc, dc; bit early, to;
        run_op(8'hFF, 8'h01, 32'h0, s, c, total, lat, bc, dc, early, to);
        checks++;
        if (s !== 8'h00 || c !== 1'b1) begin
            $display("FAIL carry_ff_01 got=%0b_%0h exp=1_00", c, s); failures++;
        end
        run_op(8'hFF, 8'hFF, 32'h0, s, c, total, lat, bc, dc, early, to);
        checks++;
        if (s !== 8'hFE || c !== 1'b1) begin
            $display("FAIL carry_ff_ff got=%0b_%0h exp=1_fe", c, s); failures++;
        end
    endtask

    task automatic test_stalls();
        logic [W-1:0] s; logic c; int total, lat, bc, dc; bit early, to;
        logic [W:0] exp;
        exp = model_add(8'h12, 8'h34);
        run_op(8'h12, 8'h34, 32'h0000_004C, s, c, total, lat, bc, dc, early, to);
        checks++;
        if (s !== exp[W-1:0] || c !== exp[W]) begin
            $display("FAIL stall_sum got=%0b_%0h exp=%0b_%0h", c, s, exp[W], exp[W-1:0]); failures++;
        end
        checks++;
        if (to || lat !== 1 || total !== W + 4 || bc !== W + 3) begin
            $display("FAIL stall_timing got lat=%0d total=%0d busy=%0d exp lat=1 total=%0d busy=%0d", lat, total, bc, W + 4, W + 3); failures++;
        end
        checks++;
        if (early) begin
            $display("FAIL stall_partial_visible got early_change=1 exp 0"); failures++;
        end
    endtask

    task automatic test_abort();
        int dc = 0;
        logic [W-1:0] a2 = 8'h01;
        logic [W-1:0] b2 = 8'h02;
        start = 1'b1; in_valid = 1'b0; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 1'b0; in_b = 1'b0; tick();
            if (done) dc++;
        end
        start = 1'b1; in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL abort_busy got=%0b exp=1", busy); failures++;
        end
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1; in_a = a2[i]; in_b = b2[i]; tick();
            if (done) dc++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dc++;
        end
        checks++;
        if (sum_out !== 8'h03 || carry_out !== 1'b0 || dc !== 1) begin
            $display("FAIL abort_result got=%0b_%0h dones=%0d exp=0_03 dones=1", carry_out, sum_out, dc); failures++;
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] s; logic c; int total, lat, bc, dc; bit early, to;
        run_op(8'hFF, 8'hFF, 32'h0, s, c, total, lat, bc, dc, early, to);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 1'($urandom); in_b = 1'($urandom); tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sum_out !== 8'h00 || carry_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL async_reset got sum=%0h c=%0b busy=%0b done=%0b exp all zero", sum_out, carry_out, busy, done); failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(8'h80, 8'h80, 32'h0, s, c, total, lat, bc, dc, early, to);
        checks++;
        if (s !== 8'h00 || c !== 1'b1 || to) begin
            $display("FAIL post_reset_add got=%0b_%0h timeout=%0b exp=1_00", c, s, to); failures++;
        end
    endtask

    task automatic test_enable_freeze();
        logic [W-1:0] a, b;
        logic [W:0] exp;
        bit hold_bad = 1'b0;
        int dc = 0;
        a = 8'($urandom); b = 8'($urandom);
        exp = model_add(a, b);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = a[i]; in_b = b[i]; tick();
        end
        ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = 1'($urandom); in_b = 1'($urandom); tick();
            if (busy !== 1'b1 || done !== 1'b0) hold_bad = 1'b1;
        end
        ena = 1'b1;
        for (int i = 3; i < W; i++) begin
            in_valid = 1'b1; in_a = a[i]; in_b = b[i]; tick();
            if (i < W - 1 && busy !== 1'b1) hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dc++;
        end
        checks++;
        if (hold_bad) begin
            $display("FAIL enable_hold got busy/done changed while frozen exp held"); failures++;
        end
        checks++;
        if (sum_out !== exp[W-1:0] || carry_out !== exp[W] || dc !== 1) begin
            $display("FAIL enable_result got=%0b_%0h dones=%0d exp=%0b_%0h dones=1", carry_out, sum_out, dc, exp[W], exp[W-1:0]); failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic [W:0] e1, e2;
        int dc = 0;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        e1 = model_add(a1, b1); e2 = model_add(a2, b2);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1; in_a = a1[i]; in_b = b1[i]; tick();
        end
        start = 1'b1; in_valid = 1'b0; tick(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || sum_out !== e1[W-1:0] || carry_out !== e1[W]) begin
            $display("FAIL b2b_first got done=%0b busy=%0b res=%0b_%0h exp done=1 busy=1 res=%0b_%0h",
                     done, busy, carry_out, sum_out, e1[W], e1[W-1:0]); failures++;
        end
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1; in_a = a2[i]; in_b = b2[i]; tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dc++;
        end
        checks++;
        if (sum_out !== e2[W-1:0] || carry_out !== e2[W] || dc !== 1) begin
            $display("FAIL b2b_second got=%0b_%0h dones=%0d exp=%0b_%0h dones=1", carry_out, sum_out, dc, e2[W], e2[W-1:0]); failures++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s; logic c; int total, lat, bc, dc; bit early, to;
        logic [W:0] exp;
        logic [31:0] stall;
        for (int n = 0; n < 10; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            stall = $urandom & $urandom & 32'h0000_0FFF;
            exp = model_add(a, b);
            run_op(a, b, stall, s, c, total, lat, bc, dc, early, to);
            checks++;
            if (s !== exp[W-1:0] || c !== exp[W] || to || lat !== 1 || dc !== 1 || early) begin
                $display("FAIL random_%0d a=%0h b=%0h got=%0b_%0h lat=%0d dones=%0d early=%0b exp=%0b_%0h lat=1 dones=1",
                         n, a, b, c, s, lat, dc, early, exp[W], exp[W-1:0]); failures++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_stalls();
        test_abort();
        test_async_reset();
        test_enable_freeze();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_serial_adder
